// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: receive-side packet controller for a USB device.
// Tracks a packet from the first bus transition through SYNC, PID and body
// bytes to end-of-packet. It drives the PID holding register and the receive
// buffer write strobe, and it reports packet completion or error.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   d_edge         in   bus transition pulse (starts a packet from IDLE)
//   byte_received  in   pulse: rcv_data holds a new byte
//   rcv_data[7:0]  in   most recently received byte
//   eop            in   level: end-of-packet present on the bus
//   PID_err        in   PID holding register is not a legal PID
//   rx_packet[3:0] in   upper nibble of the PID holding register
//   buffer_full    in   receive buffer cannot accept a byte
//   PID_clear      out  pulse: set PID holding register to all ones
//   PID_mode       out  pulse: load rcv_data into PID holding register
//   w_enable       out  buffer write strobe for rcv_data
//   rcving         out  packet reception in progress
//   rx_done        out  pulse: packet ended cleanly
//   rx_error       out  sticky error flag, cleared by the next packet start
//   byte_count     out  data bytes written in the current packet
module usb_rx_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       d_edge,
   input  logic       byte_received,
   input  logic [7:0] rcv_data,
   input  logic       eop,
   input  logic       PID_err,
   input  logic [3:0] rx_packet,
   input  logic       buffer_full,
   output logic       PID_clear,
   output logic       PID_mode,
   output logic       w_enable,
   output logic       rcving,
   output logic       rx_done,
   output logic       rx_error,
   output logic [6:0] byte_count
);

   typedef enum logic [3:0] {
      IDLE, SYNC, PID_WAIT, PID_LOAD, PID_CHECK, BODY, DONE, ERR, ERR_EOP
   } state_t;

   typedef enum logic [1:0] {CLS_DATA, CLS_TOKEN, CLS_ACK} cls_t;

   localparam logic [7:0] SYNC_BYTE = 8'h80;
   localparam logic [6:0] MAX_DATA  = 7'd66;
   localparam logic [6:0] MAX_TOKEN = 7'd2;

   state_t     state_q, state_d;
   cls_t       cls_q, cls_d;
   logic [6:0] body_cnt_q, body_cnt_d;
   logic [6:0] byte_count_q, byte_count_d;
   logic       pid_clear_q, pid_clear_d;
   logic       w_enable_q, w_enable_d;
   logic       rx_error_q, rx_error_d;

   logic [6:0] max_body;
   logic [6:0] body_inc;
   logic [6:0] cnt_at_eop;
   logic       overrun;
   logic       accept;
   logic       len_ok;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cls_q        <= CLS_ACK;
         body_cnt_q   <= '0;
         byte_count_q <= '0;
         pid_clear_q  <= 1'b0;
         w_enable_q   <= 1'b0;
         rx_error_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cls_q        <= cls_d;
         body_cnt_q   <= body_cnt_d;
         byte_count_q <= byte_count_d;
         pid_clear_q  <= pid_clear_d;
         w_enable_q   <= w_enable_d;
         rx_error_q   <= rx_error_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d      = state_q;
      cls_d        = cls_q;
      body_cnt_d   = body_cnt_q;
      byte_count_d = byte_count_q;
      pid_clear_d  = 1'b0;
      w_enable_d   = 1'b0;
      rx_error_d   = rx_error_q;

      case (cls_q)
         CLS_DATA:  max_body = MAX_DATA;
         CLS_TOKEN: max_body = MAX_TOKEN;
         default:   max_body = '0;
      endcase
      body_inc = body_cnt_q + 7'd1;
      overrun  = (body_cnt_q >= max_body);
      accept   = byte_received && !overrun && !buffer_full;
      // A byte that arrives together with eop is counted before the length check.
      cnt_at_eop = byte_received ? body_inc : body_cnt_q;
      case (cls_q)
         CLS_DATA:  len_ok = (cnt_at_eop <= MAX_DATA);
         CLS_TOKEN: len_ok = (cnt_at_eop == MAX_TOKEN);
         default:   len_ok = (cnt_at_eop == 7'd0);
      endcase

      case (state_q)
         IDLE: begin
            if (d_edge) begin
               state_d      = SYNC;
               pid_clear_d  = 1'b1;
               body_cnt_d   = '0;
               byte_count_d = '0;
               rx_error_d   = 1'b0;
            end
         end
         SYNC: begin
            if (byte_received)
               state_d = (rcv_data == SYNC_BYTE) ? PID_WAIT : ERR;
            else if (eop)
               state_d = ERR;
         end
         PID_WAIT: begin
            if (byte_received)
               state_d = PID_LOAD;
            else if (eop)
               state_d = ERR;
         end
         PID_LOAD: state_d = PID_CHECK;
         PID_CHECK: begin
            if (PID_err) begin
               state_d = ERR;
            end else begin
               state_d = BODY;
               // Legal PIDs outside data/token classes carry no body, like ACK.
               case (rx_packet)
                  4'hC, 4'hD: cls_d = CLS_DATA;
                  4'h8, 4'h9: cls_d = CLS_TOKEN;
                  default:    cls_d = CLS_ACK;
               endcase
            end
         end
         BODY: begin
            if (accept) begin
               body_cnt_d = body_inc;
               if (cls_q == CLS_DATA) begin
                  w_enable_d = 1'b1;
                  if (byte_count_q < MAX_DATA)
                     byte_count_d = byte_count_q + 7'd1;
               end
            end
            if (byte_received && !accept)
               state_d = ERR;
            else if (eop)
               state_d = len_ok ? DONE : ERR_EOP;
         end
         DONE: state_d = IDLE;
         ERR: begin
            if (eop)
               state_d = ERR_EOP;
         end
         ERR_EOP: begin
            if (!eop)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (state_d == ERR || state_d == ERR_EOP)
         rx_error_d = 1'b1;
   end

   // Outputs
   always_comb begin
      PID_clear  = pid_clear_q;
      PID_mode   = (state_q == PID_LOAD);
      w_enable   = w_enable_q;
      rcving     = (state_q != IDLE);
      rx_done    = (state_q == DONE);
      rx_error   = rx_error_q;
      byte_count = byte_count_q;
   end

endmodule
